// File: rtl/mem_wb_stage_pkg.sv
// Shared types and funct3 constants for the MEM/WB pipeline slice.
package mem_wb_stage_pkg;

  // Write-back source select
  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2
  } wb_sel_e;

  // RV32I load funct3 encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // RV32I store funct3 encodings
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

endpackage

// File: rtl/mem_wb_stage_data_memory.sv
// Single-port data memory: synchronous read, four byte-lane write enables.
// Contents have no reset.
module data_memory #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic [AW-1:0]         addr,
  input  logic                  we,
  input  logic [3:0]            be,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int unsigned LaneW = DATA_WIDTH / 4;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Read-first port: the read returns the word as it was before this edge's write
  always_ff @(posedge clk) begin
    rdata <= mem_q[addr];
    if (we) begin
      for (int l = 0; l < 4; l++) begin
        if (be[l]) begin
          mem_q[addr][l*LaneW +: LaneW] <= wdata[l*LaneW +: LaneW];
        end
      end
    end
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM and WB pipeline stages: EX/MEM register, data memory access, MEM/WB register
// and write-back mux. Optional macro SUBWORD_ACCESS_EN enables byte/halfword access.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DMEM_DEPTH = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] EX_alu_result_i,
  input  logic [DATA_WIDTH-1:0] EX_rs2_data_i,
  input  logic [DATA_WIDTH-1:0] EX_pc_plus4_i,
  input  logic [ADDR_WIDTH-1:0] EX_rd_addr_i,
  input  logic                  EX_reg_we_i,
  input  logic                  EX_mem_re_i,
  input  logic                  EX_mem_we_i,
  input  logic [2:0]            EX_funct3_i,
  input  wb_sel_e               EX_wb_sel_i,
  output logic                  WB_we,
  output logic [ADDR_WIDTH-1:0] WB_wr_addr,
  output logic [DATA_WIDTH-1:0] WB_wr_data,
  output logic                  misalign_o
);

  localparam int unsigned IdxW  = $clog2(DMEM_DEPTH);
  localparam int unsigned LaneW = DATA_WIDTH / 4;

  // EX/MEM register
  logic [DATA_WIDTH-1:0] exm_alu_q, exm_rs2_q, exm_pc4_q;
  logic [ADDR_WIDTH-1:0] exm_rd_q;
  logic                  exm_reg_we_q, exm_re_q, exm_we_q;
  logic [2:0]            exm_funct3_q;
  wb_sel_e               exm_wb_sel_q;

  // MEM/WB register
  logic [DATA_WIDTH-1:0] mwb_alu_q, mwb_pc4_q;
  logic [ADDR_WIDTH-1:0] mwb_rd_q;
  logic                  mwb_reg_we_q, mwb_load_q, mwb_mis_q;
  logic [2:0]            mwb_funct3_q;
  logic [1:0]            mwb_off_q;
  wb_sel_e               mwb_wb_sel_q;

  // MEM-stage combinational signals
  logic [1:0]            off;
  logic                  is_load, is_store, mis, mem_we;
  logic [3:0]            be;
  logic [DATA_WIDTH-1:0] wdata, rdata, load_data;

  // Capture EX inputs; reset drops any pending store
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exm_alu_q    <= '0;
      exm_rs2_q    <= '0;
      exm_pc4_q    <= '0;
      exm_rd_q     <= '0;
      exm_reg_we_q <= 1'b0;
      exm_re_q     <= 1'b0;
      exm_we_q     <= 1'b0;
      exm_funct3_q <= '0;
      exm_wb_sel_q <= WB_ALU;
    end else begin
      exm_alu_q    <= EX_alu_result_i;
      exm_rs2_q    <= EX_rs2_data_i;
      exm_pc4_q    <= EX_pc_plus4_i;
      exm_rd_q     <= EX_rd_addr_i;
      exm_reg_we_q <= EX_reg_we_i;
      exm_re_q     <= EX_mem_re_i;
      exm_we_q     <= EX_mem_we_i;
      exm_funct3_q <= EX_funct3_i;
      exm_wb_sel_q <= EX_wb_sel_i;
    end
  end

  // Access size decode, byte lanes and misalignment; load wins over store
  always_comb begin
    off      = exm_alu_q[1:0];
    is_load  = exm_re_q;
    is_store = exm_we_q && !exm_re_q;
    mis      = 1'b0;
    be       = 4'b1111;
    wdata    = exm_rs2_q;
`ifdef SUBWORD_ACCESS_EN
    case (exm_funct3_q[1:0])
      2'b00: begin
        be    = 4'b0001 << off;
        wdata = {4{exm_rs2_q[LaneW-1:0]}};
      end
      2'b01: begin
        mis   = off[0];
        be    = off[1] ? 4'b1100 : 4'b0011;
        wdata = {2{exm_rs2_q[2*LaneW-1:0]}};
      end
      default: mis = (off != 2'b00);
    endcase
`else
    mis = (off != 2'b00);
`endif
    mis    = mis && (is_load || is_store);
    mem_we = is_store && !mis;
  end

  data_memory #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DMEM_DEPTH)
  ) u_dmem (
    .clk   (clk),
    .addr  (exm_alu_q[IdxW+1:2]),
    .we    (mem_we),
    .be    (be),
    .wdata (wdata),
    .rdata (rdata)
  );

  // MEM/WB register; load data itself is held in the memory read register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mwb_alu_q    <= '0;
      mwb_pc4_q    <= '0;
      mwb_rd_q     <= '0;
      mwb_reg_we_q <= 1'b0;
      mwb_load_q   <= 1'b0;
      mwb_mis_q    <= 1'b0;
      mwb_funct3_q <= '0;
      mwb_off_q    <= '0;
      mwb_wb_sel_q <= WB_ALU;
    end else begin
      mwb_alu_q    <= exm_alu_q;
      mwb_pc4_q    <= exm_pc4_q;
      mwb_rd_q     <= exm_rd_q;
      mwb_reg_we_q <= exm_reg_we_q;
      mwb_load_q   <= is_load;
      mwb_mis_q    <= mis;
      mwb_funct3_q <= exm_funct3_q;
      mwb_off_q    <= off;
      mwb_wb_sel_q <= exm_wb_sel_q;
    end
  end

`ifdef SUBWORD_ACCESS_EN
  logic [LaneW-1:0]   lane;
  logic [2*LaneW-1:0] half;

  // Select the addressed byte/halfword and extend it
  always_comb begin
    lane = rdata[LaneW-1:0];
    case (mwb_off_q)
      2'd1:    lane = rdata[LaneW +: LaneW];
      2'd2:    lane = rdata[2*LaneW +: LaneW];
      2'd3:    lane = rdata[3*LaneW +: LaneW];
      default: lane = rdata[LaneW-1:0];
    endcase
    half      = mwb_off_q[1] ? rdata[2*LaneW +: 2*LaneW] : rdata[2*LaneW-1:0];
    load_data = rdata;
    case (mwb_funct3_q)
      F3_LB:   load_data = {{(DATA_WIDTH-LaneW){lane[LaneW-1]}}, lane};
      F3_LBU:  load_data = {{(DATA_WIDTH-LaneW){1'b0}}, lane};
      F3_LH:   load_data = {{(DATA_WIDTH-2*LaneW){half[2*LaneW-1]}}, half};
      F3_LHU:  load_data = {{(DATA_WIDTH-2*LaneW){1'b0}}, half};
      default: load_data = rdata;
    endcase
  end
`else
  logic unused_subword;
  assign unused_subword = ^{mwb_funct3_q, mwb_off_q};

  // Full-word access only
  always_comb begin
    load_data = rdata;
  end
`endif

  // Write-back mux; x0 and misaligned loads never write the register file
  always_comb begin
    case (mwb_wb_sel_q)
      WB_MEM:  WB_wr_data = load_data;
      WB_PC4:  WB_wr_data = mwb_pc4_q;
      default: WB_wr_data = mwb_alu_q;
    endcase
    WB_we      = mwb_reg_we_q && (mwb_rd_q != '0) && !(mwb_load_q && mwb_mis_q);
    WB_wr_addr = mwb_rd_q;
    misalign_o = mwb_mis_q;
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage (define SUBWORD_ACCESS_EN for subword cases).
module tb_mem_wb_stage;
  import mem_wb_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] alu_i, rs2_i, pc4_i;
  logic [4:0]  rd_i;
  logic        rwe_i, re_i, we_i;
  logic [2:0]  f3_i;
  wb_sel_e     sel_i;
  logic        wb_we, mis;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  int checks = 0;
  int errors = 0;

  mem_wb_stage dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .EX_alu_result_i (alu_i),
    .EX_rs2_data_i   (rs2_i),
    .EX_pc_plus4_i   (pc4_i),
    .EX_rd_addr_i    (rd_i),
    .EX_reg_we_i     (rwe_i),
    .EX_mem_re_i     (re_i),
    .EX_mem_we_i     (we_i),
    .EX_funct3_i     (f3_i),
    .EX_wb_sel_i     (sel_i),
    .WB_we           (wb_we),
    .WB_wr_addr      (wb_addr),
    .WB_wr_data      (wb_data),
    .misalign_o      (mis)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [31:0] alu, input logic [31:0] rs2, input logic [31:0] pc4,
                       input logic [4:0] rd, input logic rwe, input logic re, input logic we,
                       input logic [2:0] f3, input wb_sel_e sel);
    alu_i = alu; rs2_i = rs2; pc4_i = pc4; rd_i = rd;
    rwe_i = rwe; re_i = re; we_i = we; f3_i = f3; sel_i = sel;
  endtask

  task automatic nop();
    drive(32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0, WB_ALU);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one op, then bubbles; returns with WB showing that op
  task automatic run(input logic [31:0] alu, input logic [31:0] rs2, input logic [31:0] pc4,
                     input logic [4:0] rd, input logic rwe, input logic re, input logic we,
                     input logic [2:0] f3, input wb_sel_e sel);
    drive(alu, rs2, pc4, rd, rwe, re, we, f3, sel);
    tick();
    nop();
    tick();
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] f3);
    run(addr, data, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1, f3, WB_ALU);
  endtask

  task automatic load(input logic [31:0] addr, input logic [4:0] rd, input logic [2:0] f3);
    run(addr, 32'd0, 32'd0, rd, 1'b1, 1'b1, 1'b0, f3, WB_MEM);
  endtask

  initial begin
    nop();
    #2 rst_n = 1'b0;
    #20;
    check("rst_we", {31'd0, wb_we}, 32'd0);
    check("rst_addr", {27'd0, wb_addr}, 32'd0);
    check("rst_data", wb_data, 32'd0);
    check("rst_mis", {31'd0, mis}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // ALU write-back
    run(32'd300, 32'd0, 32'd0, 5'd3, 1'b1, 1'b0, 1'b0, F3_LW, WB_ALU);
    check("alu_we", {31'd0, wb_we}, 32'd1);
    check("alu_addr", {27'd0, wb_addr}, 32'd3);
    check("alu_data", wb_data, 32'd300);
    check("alu_mis", {31'd0, mis}, 32'd0);

    // Store immediately followed by load of the same word
    drive(32'h40, 32'h12345678, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1, F3_SW, WB_ALU);
    tick();
    drive(32'h40, 32'd0, 32'd0, 5'd7, 1'b1, 1'b1, 1'b0, F3_LW, WB_MEM);
    tick();
    nop();
    tick();
    check("lw_data", wb_data, 32'h12345678);
    check("lw_we", {31'd0, wb_we}, 32'd1);
    check("lw_addr", {27'd0, wb_addr}, 32'd7);

    // x0 never written
    run(32'd55, 32'd0, 32'd0, 5'd0, 1'b1, 1'b0, 1'b0, F3_LW, WB_ALU);
    check("x0_we", {31'd0, wb_we}, 32'd0);

    // Link value
    run(32'h999, 32'd0, 32'h104, 5'd1, 1'b1, 1'b0, 1'b0, F3_LW, WB_PC4);
    check("pc4_data", wb_data, 32'h104);
    check("pc4_we", {31'd0, wb_we}, 32'd1);

    // Address wraps modulo DMEM_DEPTH*4
    load(32'h1040, 5'd8, F3_LW);
    check("wrap_data", wb_data, 32'h12345678);

    // Misaligned word load: pulse for one cycle, no write-back
    load(32'h42, 5'd9, F3_LW);
    check("mis_pulse", {31'd0, mis}, 32'd1);
    check("mis_we", {31'd0, wb_we}, 32'd0);
    tick();
    check("mis_clear", {31'd0, mis}, 32'd0);

    // Misaligned store must not write memory
    store(32'h44, 32'h11112222, F3_SW);
    store(32'h46, 32'hDEADBEEF, F3_SW);
    check("mis_st_pulse", {31'd0, mis}, 32'd1);
    load(32'h44, 5'd10, F3_LW);
    check("mis_st_nowrite", wb_data, 32'h11112222);

    // Load and store together act as a load only
    run(32'h44, 32'hBAD0BAD0, 32'd0, 5'd11, 1'b1, 1'b1, 1'b1, F3_LW, WB_MEM);
    check("rewe_data", wb_data, 32'h11112222);
    load(32'h44, 5'd12, F3_LW);
    check("rewe_nowrite", wb_data, 32'h11112222);

    // Store caught in EX/MEM by reset is discarded
    drive(32'h44, 32'h55556666, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1, F3_SW, WB_ALU);
    tick();
    nop();
    rst_n = 1'b0;
    #1;
    check("rst2_we", {31'd0, wb_we}, 32'd0);
    check("rst2_data", wb_data, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    load(32'h44, 5'd13, F3_LW);
    check("rst_discard", wb_data, 32'h11112222);
    check("rst_discard_we", {31'd0, wb_we}, 32'd1);

`ifdef SUBWORD_ACCESS_EN
    store(32'h41, 32'hFFFFFFAB, F3_SB);
    check("sb_mis", {31'd0, mis}, 32'd0);
    load(32'h41, 5'd14, F3_LB);
    check("lb_data", wb_data, 32'hFFFFFFAB);
    check("lb_we", {31'd0, wb_we}, 32'd1);
    load(32'h41, 5'd15, F3_LBU);
    check("lbu_data", wb_data, 32'h000000AB);
    load(32'h40, 5'd16, F3_LW);
    check("sb_word", wb_data, 32'h1234AB78);
    load(32'h42, 5'd17, F3_LHU);
    check("lhu_data", wb_data, 32'h00001234);
    store(32'h46, 32'h0000F00D, F3_SH);
    load(32'h46, 5'd18, F3_LH);
    check("lh_data", wb_data, 32'hFFFFF00D);
    load(32'h44, 5'd19, F3_LW);
    check("sh_word", wb_data, 32'hF00D2222);
    load(32'h43, 5'd20, F3_LH);
    check("lh_mis", {31'd0, mis}, 32'd1);
    check("lh_mis_we", {31'd0, wb_we}, 32'd0);
`else
    // Without subword support funct3 is ignored: byte offset is misaligned
    load(32'h41, 5'd14, F3_LB);
    check("lb_full_mis", {31'd0, mis}, 32'd1);
    check("lb_full_we", {31'd0, wb_we}, 32'd0);
    store(32'h40, 32'h000000AB, F3_SB);
    load(32'h40, 5'd15, F3_LBU);
    check("sb_full_word", wb_data, 32'h000000AB);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 Parameter DATA_WIDTH, default 32: datapath width.
REQ-002 Parameter ADDR_WIDTH, default 5: register-file address width.
REQ-003 Parameter DMEM_DEPTH, default 1024: data-memory words, power of two.
REQ-004 One clock and one reset: reset is asynchronous and active-low.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 EX_alu_result_i  input  DATA_WIDTH  ALU result, or byte address for loads/stores.
REQ-008 EX_rs2_data_i  input  DATA_WIDTH  store data.
REQ-009 EX_pc_plus4_i  input  DATA_WIDTH  link value for jal/jalr.
REQ-010 EX_rd_addr_i  input  ADDR_WIDTH  destination register.
REQ-011 EX_reg_we_i, EX_mem_re_i, EX_mem_we_i  input  1 each  register write, load, store.
REQ-012 EX_funct3_i  input  3  access size and signedness (RV32I encoding).
REQ-013 EX_wb_sel_i  input  wb_sel_e (2)  write-back source: ALU, MEM or PC4.
REQ-014 WB_we  output  1  register-file write enable.
REQ-015 WB_wr_addr  output  ADDR_WIDTH  register-file write address.
REQ-016 WB_wr_data  output  DATA_WIDTH  register-file write data.
REQ-017 misalign_o  output  1  one-cycle pulse for a misaligned access.

Function
REQ-018 Edge 1 SHALL capture all EX_* inputs into the EX/MEM register.
REQ-019 Edge 2 SHALL perform the data-memory access.
- Store: write dmem[addr[log2(DMEM_DEPTH)+1:2]].
- Load: synchronous read into the MEM/WB register.
- The same edge SHALL capture the EX/MEM control, ALU result and PC+4 into MEM/WB.
REQ-020 WB_* SHALL be driven combinationally from MEM/WB after edge 2: fixed latency of 2 clocks from EX input to WB output, with one new operation accepted every cycle.
REQ-021 WB_wr_data SHALL be selected by wb_sel.
- ALU: the ALU result.
- MEM: the load-extended memory data.
- PC4: the PC+4 value.
REQ-022 WB_we SHALL equal the registered reg_we, forced to 0 when rd is 0 or when a load is misaligned.
REQ-023 Word address bits above the memory index SHALL be ignored (address wraps modulo DMEM_DEPTH*4).
REQ-024 A load immediately following a store to the same word SHALL return the newly stored data.
REQ-025 Misalignment SHALL be detected: word access with addr[1:0]!=0, or halfword access with addr[0]!=0.
- A misaligned store SHALL not write memory.
- A misaligned load SHALL not write back.
- misalign_o SHALL pulse high for the cycle in which WB outputs reflect that access.
REQ-026 When EX_mem_re_i and EX_mem_we_i are both 1, the store SHALL be ignored and the op treated as a load.

Reset
REQ-027 While rst_n=0, both pipeline registers SHALL clear: WB_we=0, WB_wr_addr=0, WB_wr_data=0, misalign_o=0.
REQ-028 Data-memory contents SHALL not be cleared by reset.
REQ-029 A store held in EX/MEM when reset asserts SHALL be discarded (no memory write).
REQ-030 The first valid WB output SHALL appear 2 edges after reset is released and the first input is presented.

Configuration
REQ-031 Macro SUBWORD_ACCESS_EN controls subword access.
- Defined: funct3 LB/LH/LW/LBU/LHU and SB/SH/SW SHALL be supported, with byte-lane write enables; LB/LH sign-extend, LBU/LHU zero-extend.
- Undefined: every access SHALL be a full word regardless of funct3, and only addr[1:0]!=0 counts as misaligned.

Structure
REQ-032 Package defines SHALL hold wb_sel_e {WB_ALU, WB_MEM, WB_PC4} and the funct3 load/store constants.
REQ-033 Sub-module data_memory SHALL implement single-port synchronous-read storage with 4-bit byte write enable and DMEM_DEPTH words.

Verification
REQ-034 ALU write-back: alu=300, rd=3, reg_we=1, wb_sel=ALU -> two edges later WB_we=1, WB_wr_addr=3, WB_wr_data=300.
REQ-035 Word store/load: sw 0x12345678 to 0x40, then next cycle lw rd=7 from 0x40 -> WB_wr_data=0x12345678, WB_we=1.
REQ-036 x0 protection: alu=55, rd=0, reg_we=1 -> WB_we=0.
REQ-037 Subword (SUBWORD_ACCESS_EN): sb 0xAB to 0x41, then:
- lb 0x41 -> 0xFFFFFFAB;
- lbu 0x41 -> 0x000000AB;
- lw 0x40 -> byte 1 = 0xAB, other bytes unchanged.
REQ-038 Misalignment and reset: lw from 0x42 -> misalign_o=1, WB_we=0. sw to 0x44 with rst_n dropped before edge 2 -> a later lw 0x44 returns the prior contents.
